serial_tx_param: RTL and testbench

Parametrised UART transmitter, the next generation of the single-byte 8N1 transmitter.
- Configurable data width, parity mode and stop-bit count.
- Small input FIFO so producers can queue words; queued words go out back-to-back with no idle gap.
- Sits between packet/telemetry logic and the board TX pin, in the same clock domain as the producer.

---
 rtl/serial_tx_param.sv | 242 ++++++++++++++++++++++++
 tb/tb_serial_tx_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_param.sv
// Parametrised UART transmitter with input FIFO, configurable data bits, parity and stop bits.
// Optional line-break generation is enabled by defining SERIAL_TX_BREAK_EN.
`timescale 1ns/1ps
module serial_tx_param #(
    parameter int BAUDRATE        = 115200,
    parameter int CLOCK_FREQUENCY = 48000000,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
`ifdef SERIAL_TX_BREAK_EN
    input  logic                          i_Break,
`endif
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUDRATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W        = $clog2(DATA_BITS + 1);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int FCNT_W       = PTR_W + 1;

    localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] FULL      = FCNT_W'(FIFO_DEPTH);

`ifdef SERIAL_TX_BREAK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK, S_MAB
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`endif

    state_t               state_q;
    logic [CNT_W-1:0]     baud_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [FCNT_W-1:0]    count_q;
    logic [FCNT_W-1:0]    count_d;
    logic                 ready_q;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 tick_last;

    assign fifo_empty = (count_q == '0);
    assign tick_last  = (baud_q == LAST_TICK);
    assign push       = i_Tx_DV & ready_q;

    // Pop only at a frame boundary: from IDLE, at the last stop tick, or after mark-after-break.
    always_comb begin
        pop = 1'b0;
        case (state_q)
`ifdef SERIAL_TX_BREAK_EN
            S_IDLE:  pop = ~fifo_empty & ~i_Break;
            S_MAB:   pop = tick_last & ~fifo_empty;
`else
            S_IDLE:  pop = ~fifo_empty;
`endif
            S_STOP:  pop = tick_last & (idx_q == LAST_STOP) & ~fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ready_q <= (count_d != FULL);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // Parity is fixed when the word is loaded, so the shifting register never has to be re-scanned.
    always_ff @(posedge i_Clock) begin
        if (pop) begin
            shift_q <= mem[rd_ptr_q];
            par_q   <= (PARITY == 1) ? ~^mem[rd_ptr_q] : ^mem[rd_ptr_q];
        end else if (state_q == S_DATA && tick_last) begin
            shift_q <= shift_q >> 1;
        end
    end

    // Outputs are registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= (state_q == S_STOP) && tick_last && (idx_q == LAST_STOP);
            active_q <= (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
            case (state_q)
                S_IDLE: begin
                    serial_q <= 1'b1;
                    baud_q   <= '0;
                    idx_q    <= '0;
`ifdef SERIAL_TX_BREAK_EN
                    if (i_Break) begin
                        state_q <= S_BRK;
                    end else if (pop) begin
                        state_q <= S_START;
                    end
`else
                    if (pop) begin
                        state_q <= S_START;
                    end
`endif
                end
                S_START: begin
                    serial_q <= 1'b0;
                    if (tick_last) begin
                        baud_q  <= '0;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    serial_q <= shift_q[0];
                    if (tick_last) begin
                        baud_q <= '0;
                        if (idx_q == LAST_DATA) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    serial_q <= par_q;
                    if (tick_last) begin
                        baud_q  <= '0;
                        idx_q   <= '0;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    serial_q <= 1'b1;
                    if (tick_last) begin
                        baud_q <= '0;
                        if (idx_q == LAST_STOP) begin
                            idx_q   <= '0;
                            state_q <= pop ? S_START : S_IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef SERIAL_TX_BREAK_EN
                S_BRK: begin
                    serial_q <= 1'b0;
                    baud_q   <= '0;
                    if (!i_Break) begin
                        state_q <= S_MAB;
                    end
                end
                S_MAB: begin
                    serial_q <= 1'b1;
                    if (tick_last) begin
                        baud_q  <= '0;
                        state_q <= pop ? S_START : S_IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                default: begin
                    serial_q <= 1'b1;
                    baud_q   <= '0;
                    idx_q    <= '0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Ready   = ready_q;
    assign o_Fifo_Count = count_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Done    = done_q;

endmodule

// File: tb/tb_serial_tx_param.sv
// Bench for serial_tx_param: three configurations (8N1, 7E2, 8O1) share stimulus and are
// compared every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_serial_tx_param;

    localparam int NI  = 3;
    localparam int CPB = 10;
    localparam int DB  [NI] = '{8, 7, 8};
    localparam int PAR [NI] = '{0, 2, 1};
    localparam int SB  [NI] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;

    logic       ser  [NI];
    logic       act  [NI];
    logic       done [NI];
    logic       rdy  [NI];
    logic [2:0] cnt  [NI];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_tx_param #(
            .BAUDRATE(100000), .CLOCK_FREQUENCY(1000000), .DATA_BITS(DB[g]),
            .PARITY(PAR[g]), .STOP_BITS(SB[g]), .FIFO_DEPTH(4)
        ) u_dut (
            .i_Clock(clk),
            .i_Rst_n(rst_n),
`ifdef SERIAL_TX_BREAK_EN
            .i_Break(1'b0),
`endif
            .i_Tx_DV(tx_dv),
            .i_Tx_Byte(tx_byte[DB[g]-1:0]),
            .o_Tx_Ready(rdy[g]),
            .o_Fifo_Count(cnt[g]),
            .o_Tx_Active(act[g]),
            .o_Tx_Serial(ser[g]),
            .o_Tx_Done(done[g])
        );
    end

    function automatic int flen(input int g);
        return (1 + DB[g] + ((PAR[g] != 0) ? 1 : 0) + SB[g]) * CPB;
    endfunction

    // Line level during bit-time b of a frame carrying word w.
    function automatic logic line_lvl(input int g, input logic [7:0] w, input int b);
        logic [7:0] m;
        m = w & 8'((1 << DB[g]) - 1);
        if (b == 0) return 1'b0;
        if (b <= DB[g]) return m[b-1];
        if (PAR[g] != 0 && b == DB[g] + 1) return (PAR[g] == 1) ? ~^m : ^m;
        return 1'b1;
    endfunction

    // Reference model: a word queue plus the start edge of the frame currently on the line.
    logic [7:0] mq [NI][$];
    int         fs [NI];
    logic [7:0] fw [NI];
    bit         busy [NI];
    bit         fv [NI];
    logic       e_ser [NI];
    logic       e_act [NI];
    logic       e_done [NI];
    logic       e_rdy [NI];
    logic [2:0] e_cnt [NI];
    int         k;
    int         m_nb;
    bit         m_pop;

    initial begin
        k = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0;
                for (int g = 0; g < NI; g++) begin
                    mq[g].delete();
                    busy[g] = 0; fv[g] = 0; fs[g] = 0; fw[g] = 8'h00;
                    e_ser[g] = 1'b1; e_act[g] = 1'b0; e_done[g] = 1'b0;
                    e_rdy[g] = 1'b1; e_cnt[g] = 3'd0;
                end
            end else begin
                k = k + 1;
                for (int g = 0; g < NI; g++) begin
                    if (fv[g] && k >= fs[g] && k <= fs[g] + flen(g) - 1) begin
                        e_ser[g] = line_lvl(g, fw[g], (k - fs[g]) / CPB);
                        e_act[g] = 1'b1;
                    end else begin
                        e_ser[g] = 1'b1;
                        e_act[g] = 1'b0;
                    end
                    m_nb = mq[g].size();
                    m_pop = 0;
                    e_done[g] = 1'b0;
                    if (busy[g] && k == fs[g] + flen(g) - 1) begin
                        e_done[g] = 1'b1;
                        if (m_nb > 0) m_pop = 1; else busy[g] = 0;
                    end else if (!busy[g] && m_nb > 0) begin
                        m_pop = 1;
                    end
                    if (m_pop) begin
                        fw[g] = mq[g].pop_front();
                        fs[g] = k + 1;
                        busy[g] = 1;
                        fv[g] = 1;
                    end
                    if (tx_dv && m_nb != 4) mq[g].push_back(tx_byte & 8'((1 << DB[g]) - 1));
                    e_cnt[g] = 3'(mq[g].size());
                    e_rdy[g] = (mq[g].size() != 4);
                end
            end
        end
    end

    task automatic test_reset();
        tx_dv = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            tests++;
            if (ser[g] !== 1'b1 || rdy[g] !== 1'b1 || cnt[g] !== 3'd0 || act[g] !== 1'b0 || done[g] !== 1'b0) begin
                fails++;
                $display("FAIL reset[%0d] ser/rdy/cnt/act/done=%b/%b/%0d/%b/%b required 1/1/0/0/0",
                         g, ser[g], rdy[g], cnt[g], act[g], done[g]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            tests++;
            if ({ser[g], act[g], done[g], rdy[g], cnt[g]} !== {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]}) begin
                fails++;
                $display("FAIL reset_release[%0d] got %b required %b", g,
                         {ser[g], act[g], done[g], rdy[g], cnt[g]}, {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]});
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] w, input int gsel, input logic [10:0] want);
        logic [10:0] samp [NI];
        int ndone [NI];
        int dpos [NI];
        int nact [NI];
        for (int g = 0; g < NI; g++) begin
            samp[g] = '1; ndone[g] = 0; dpos[g] = -1; nact[g] = 0;
        end
        tx_byte = w;
        tx_dv = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        for (int i = 0; i <= 130; i++) begin
            if (i > 0) @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                tests++;
                if ({ser[g], act[g], done[g], rdy[g], cnt[g]} !== {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]}) begin
                    fails++;
                    $display("FAIL frame_%02h[%0d] cyc %0d ser/act/done/rdy/cnt got %b required %b", w, g, i,
                             {ser[g], act[g], done[g], rdy[g], cnt[g]}, {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]});
                end
                if (done[g] === 1'b1) begin ndone[g]++; dpos[g] = i; end
                if (act[g] === 1'b1) nact[g]++;
                for (int b = 0; b < 11; b++) begin
                    if (i == 7 + CPB * b) samp[g][b] = ser[g];
                end
            end
        end
        for (int g = 0; g < NI; g++) begin
            tests++;
            if (ndone[g] != 1 || dpos[g] != flen(g) + 1 || nact[g] != flen(g)) begin
                fails++;
                $display("FAIL frame_timing_%02h[%0d] done_count=%0d done_at=%0d active_cycles=%0d required 1/%0d/%0d",
                         w, g, ndone[g], dpos[g], nact[g], flen(g) + 1, flen(g));
            end
        end
        tests++;
        if (samp[gsel] !== want) begin
            fails++;
            $display("FAIL frame_bits_%02h[%0d] got %b required %b", w, gsel, samp[gsel], want);
        end
    endtask

    task automatic test_fifo_burst();
        int ndone [NI];
        int nact [NI];
        int rises [NI];
        logic pact [NI];
        for (int g = 0; g < NI; g++) begin
            ndone[g] = 0; nact[g] = 0; rises[g] = 0; pact[g] = 1'b0;
        end
        for (int i = 0; i < 626; i++) begin
            if (i < 6) begin
                tx_byte = 8'($urandom);
                tx_dv = 1'b1;
            end else begin
                tx_dv = 1'b0;
            end
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                tests++;
                if ({ser[g], act[g], done[g], rdy[g], cnt[g]} !== {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]}) begin
                    fails++;
                    $display("FAIL burst[%0d] cyc %0d ser/act/done/rdy/cnt got %b required %b", g, i,
                             {ser[g], act[g], done[g], rdy[g], cnt[g]}, {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]});
                end
                if (i == 5) begin
                    tests++;
                    if (cnt[g] !== 3'd4 || rdy[g] !== 1'b0) begin
                        fails++;
                        $display("FAIL burst_full[%0d] cnt=%0d ready=%b required 4/0", g, cnt[g], rdy[g]);
                    end
                end
                if (done[g] === 1'b1) ndone[g]++;
                if (act[g] === 1'b1) nact[g]++;
                if (act[g] === 1'b1 && pact[g] === 1'b0) rises[g]++;
                pact[g] = act[g];
            end
        end
        for (int g = 0; g < NI; g++) begin
            tests++;
            if (ndone[g] != 5 || nact[g] != 5 * flen(g) || rises[g] != 1) begin
                fails++;
                $display("FAIL burst_frames[%0d] done=%0d active_cycles=%0d active_bursts=%0d required 5/%0d/1",
                         g, ndone[g], nact[g], rises[g], 5 * flen(g));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2700; i++) begin
            tx_dv = (i < 2000) && ($urandom_range(0, 3) == 0);
            tx_byte = 8'($urandom);
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                tests++;
                if ({ser[g], act[g], done[g], rdy[g], cnt[g]} !== {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]}) begin
                    fails++;
                    $display("FAIL random[%0d] cyc %0d ser/act/done/rdy/cnt got %b required %b", g, i,
                             {ser[g], act[g], done[g], rdy[g], cnt[g]}, {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]});
                end
            end
        end
        tx_dv = 1'b0;
        for (int g = 0; g < NI; g++) begin
            tests++;
            if (ser[g] !== 1'b1 || act[g] !== 1'b0 || cnt[g] !== 3'd0 || rdy[g] !== 1'b1) begin
                fails++;
                $display("FAIL random_drained[%0d] ser/act/cnt/rdy=%b/%b/%0d/%b required 1/0/0/1",
                         g, ser[g], act[g], cnt[g], rdy[g]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i <= 150; i++) begin
            tx_dv = (i < 3);
            tx_byte = 8'($urandom);
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                tests++;
                if ({ser[g], act[g], done[g], rdy[g], cnt[g]} !== {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]}) begin
                    fails++;
                    $display("FAIL midrst_pre[%0d] cyc %0d ser/act/done/rdy/cnt got %b required %b", g, i,
                             {ser[g], act[g], done[g], rdy[g], cnt[g]}, {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]});
                end
            end
        end
        tx_dv = 1'b0;
        for (int g = 0; g < NI; g++) begin
            tests++;
            if (cnt[g] !== 3'd1 || act[g] !== 1'b1) begin
                fails++;
                $display("FAIL midrst_busy[%0d] cnt=%0d act=%b required 1/1", g, cnt[g], act[g]);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            tests++;
            if (ser[g] !== 1'b1 || cnt[g] !== 3'd0 || act[g] !== 1'b0 || rdy[g] !== 1'b1 || done[g] !== 1'b0) begin
                fails++;
                $display("FAIL midrst_async[%0d] ser/cnt/act/rdy/done=%b/%0d/%b/%b/%b required 1/0/0/1/0",
                         g, ser[g], cnt[g], act[g], rdy[g], done[g]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                tests++;
                if (ser[g] !== 1'b1 || act[g] !== 1'b0 ||
                    {ser[g], act[g], done[g], rdy[g], cnt[g]} !== {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]}) begin
                    fails++;
                    $display("FAIL midrst_after[%0d] cyc %0d ser/act/done/rdy/cnt got %b required %b", g, i,
                             {ser[g], act[g], done[g], rdy[g], cnt[g]}, {e_ser[g], e_act[g], e_done[g], e_rdy[g], e_cnt[g]});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, 0, 11'b111_0100_1010);
        test_frame(8'h53, 1, 11'b110_1010_0110);
        test_frame(8'h00, 2, 11'b110_0000_0000);
        test_frame(8'h01, 2, 11'b100_0000_0010);
        test_fifo_burst();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
